// File: rtl/posit_defines_es3.sv
// Shared constants, helpers and the stage-2 record for the es=3 posit accumulate path.
package posit_defines_es3;

    localparam int ES3 = 3;
    localparam int POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES3 = 265;
    localparam int SCALE_W = 10;
    localparam int FRAC_W = 252;
    localparam int BODY_MAX_W = 31;

    function automatic int posit_maxscale_es3(input int n);
        return (1 << ES3) * (n - 2);
    endfunction

    // Body is sized for the widest legal posit; narrower instances use the low N-1 bits.
    typedef struct packed {
        logic                  sgn;
        logic                  inf;
        logic                  zero;
        logic                  sat;
        logic [BODY_MAX_W-1:0] body;
        logic                  guard;
        logic                  sticky;
    } round_rec_t;

endpackage

// File: rtl/posit_round_ne_es3.sv
// Combinational round-to-nearest-even, saturation and negation of a packed posit body.
module posit_round_ne_es3
    import posit_defines_es3::*;
#(
    parameter int N = 16
) (
    input  round_rec_t   rec,
    output logic [N-1:0] posit,
    output logic         inexact
);

    localparam int BW = N - 1;

    logic [BW-1:0] body;
    logic [BW-1:0] mag;
    logic [N-1:0]  sum;
    logic          inc;

    always_comb begin
        body    = rec.body[BW-1:0];
        inc     = rec.guard & (body[0] | rec.sticky);
        sum     = {1'b0, body} + {{BW{1'b0}}, inc};
        mag     = body;
        inexact = 1'b0;
        posit   = '0;
        if (rec.inf) begin
            posit = {1'b1, {BW{1'b0}}};
        end else if (!rec.zero) begin
            if (rec.sat) begin
                inexact = 1'b1;
            end else begin
                // Rounding may neither overflow past maxpos nor collapse to zero.
                if (sum[N-1])
                    mag = '1;
                else if (sum[BW-1:0] == '0)
                    mag = BW'(1);
                else
                    mag = sum[BW-1:0];
                inexact = rec.guard | rec.sticky;
            end
            posit = rec.sgn ? -{1'b0, mag} : {1'b0, mag};
        end
    end

    generate
        if (BW < BODY_MAX_W) begin : g_narrow
            logic unused_body_hi;
            assign unused_body_hi = |rec.body[BODY_MAX_W-1:BW];
        end
    endgenerate

endmodule

// File: rtl/shift_right.sv
// Logical right shift with a selectable fill bit shifted in from the MSB side.
module shift_right #(
    parameter int W    = 8,
    parameter int SH_W = 3
) (
    input  logic [W-1:0]    data,
    input  logic [SH_W-1:0] amt,
    input  logic            fill,
    output logic [W-1:0]    out
);

    assign out = (data >> amt) | ({W{fill}} & ~({W{1'b1}} >> amt));

endmodule

// File: rtl/posit_accum_round_16_es3.sv
// Serialized es3 accumulator value -> packed N-bit posit, RNE, 3-stage pipeline.
// Optional: POSIT_ACCUM_ROUND_TRUNC_EN folds in_truncated into sticky/inexact.
module posit_accum_round_16_es3
    import posit_defines_es3::*;
#(
    parameter int N = 16
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES3-1:0] in_raw,
    input  logic                                             in_valid,
    input  logic                                             in_truncated,
    output logic [N-1:0]                                     out_posit,
    output logic                                             out_valid,
    output logic                                             out_inexact
);

    localparam int MAXSCALE = posit_maxscale_es3(N);
    localparam int SH_W     = $clog2(N);
    localparam int KW       = SCALE_W - ES3;
    localparam int SEED_W   = 1 + ES3 + FRAC_W;
    localparam int VEC_W    = SEED_W + N;
    localparam int STAGES   = 3;

    logic [STAGES:1] vld_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    // ---- stage 1: field split, clamp detection, regime shift amount
    logic signed [SCALE_W-1:0] scale;
    logic signed [KW-1:0]      k;
    logic [ES3-1:0]            e;
    logic [FRAC_W-1:0]         frac;
    logic                      sat_hi, sat_lo;
    logic [SH_W-1:0]           shamt;

    assign scale  = in_raw[FRAC_W+2 +: SCALE_W];
    assign frac   = in_raw[2 +: FRAC_W];
    assign k      = scale[SCALE_W-1:ES3];
    assign e      = scale[ES3-1:0];
    assign sat_hi = scale > MAXSCALE;
    assign sat_lo = scale < -MAXSCALE;
    // Positive k: k+1 ones shifted in ahead of the terminating 0; negative k: -k zeros ahead of the 1.
    assign shamt  = k[KW-1] ? SH_W'(-k) : SH_W'(k + 1);

    logic              s1_sgn, s1_inf, s1_zero, s1_sat_hi, s1_sat_lo, s1_fill;
    logic [SH_W-1:0]   s1_shamt;
    logic [SEED_W-1:0] s1_seed;

    always_ff @(posedge clk) begin
        s1_sgn    <= in_raw[POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES3-1];
        s1_inf    <= in_raw[1];
        s1_zero   <= in_raw[0];
        s1_sat_hi <= sat_hi;
        s1_sat_lo <= sat_lo;
        s1_fill   <= ~k[KW-1];
        s1_shamt  <= shamt;
        s1_seed   <= {k[KW-1], e, frac};
    end

`ifdef POSIT_ACCUM_ROUND_TRUNC_EN
    logic s1_trunc;
    always_ff @(posedge clk) s1_trunc <= in_truncated;
`else
    logic unused_trunc;
    assign unused_trunc = in_truncated;
`endif

    // ---- stage 2: packing shift and body/guard/sticky extraction
    logic [VEC_W-1:0] packed_vec;
    round_rec_t       rec_d, s2_q;

    shift_right #(
        .W    (VEC_W),
        .SH_W (SH_W)
    ) u_pack (
        .data ({s1_seed, {N{1'b0}}}),
        .amt  (s1_shamt),
        .fill (s1_fill),
        .out  (packed_vec)
    );

    always_comb begin
        rec_d      = '0;
        rec_d.sgn  = s1_sgn;
        rec_d.inf  = s1_inf;
        rec_d.zero = s1_zero;
        rec_d.sat  = s1_sat_hi | s1_sat_lo;
        if (s1_sat_hi) begin
            rec_d.body[N-2:0] = '1;
        end else if (s1_sat_lo) begin
            rec_d.body[N-2:0] = (N-1)'(1);
        end else begin
            rec_d.body[N-2:0] = packed_vec[VEC_W-1 -: N-1];
            rec_d.guard       = packed_vec[VEC_W-N];
`ifdef POSIT_ACCUM_ROUND_TRUNC_EN
            rec_d.sticky      = (|packed_vec[VEC_W-N-1:0]) | s1_trunc;
`else
            rec_d.sticky      = |packed_vec[VEC_W-N-1:0];
`endif
        end
    end

    always_ff @(posedge clk) s2_q <= rec_d;

    // ---- stage 3: round, saturate, negate, register outputs
    logic [N-1:0] rnd_posit;
    logic         rnd_inexact;

    posit_round_ne_es3 #(
        .N (N)
    ) u_round (
        .rec     (s2_q),
        .posit   (rnd_posit),
        .inexact (rnd_inexact)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_posit   <= '0;
            out_inexact <= 1'b0;
        end else begin
            out_posit   <= rnd_posit;
            out_inexact <= rnd_inexact;
        end
    end

    assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_posit_accum_round_16_es3.sv
// Directed vector table plus streaming and mid-stream reset sequences.
module tb_posit_accum_round_16_es3;
    import posit_defines_es3::*;

    localparam int N = 16;

    typedef struct {
        logic              sgn;
        logic [9:0]        scale;
        logic [FRAC_W-1:0] frac;
        logic              inf;
        logic              zero;
        logic              trunc;
        logic [N-1:0]      posit;
        logic              inexact;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES3-1:0] in_raw = '0;
    logic in_valid = 1'b0;
    logic in_truncated = 1'b0;
    logic [N-1:0] out_posit;
    logic out_valid, out_inexact;

    int tests = 0;
    int fails = 0;
    vec_t vecs[20];

    posit_accum_round_16_es3 #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_raw       (in_raw),
        .in_valid     (in_valid),
        .in_truncated (in_truncated),
        .out_posit    (out_posit),
        .out_valid    (out_valid),
        .out_inexact  (out_inexact)
    );

    always #5 clk = ~clk;

    function automatic logic [FRAC_W-1:0] fb(input int raw_idx);
        logic [FRAC_W-1:0] f;
        f = '0;
        f[raw_idx-2] = 1'b1;
        return f;
    endfunction

    function automatic vec_t mk(input logic sgn, input int scale, input logic [FRAC_W-1:0] frac,
                                input logic inf, input logic zero, input logic trunc,
                                input logic [N-1:0] posit, input logic inexact);
        vec_t v;
        v.sgn = sgn; v.scale = 10'(scale); v.frac = frac;
        v.inf = inf; v.zero = zero; v.trunc = trunc;
        v.posit = posit; v.inexact = inexact;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic vld);
        in_raw       = {v.sgn, v.scale, v.frac, v.inf, v.zero};
        in_truncated = v.trunc;
        in_valid     = vld;
    endtask

    task automatic run_vec(input int i);
        @(negedge clk);
        drive(vecs[i], 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_early", i), 32'(out_valid), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d_posit", i), 32'(out_posit), 32'(vecs[i].posit));
        chk($sformatf("v%0d_inexact", i), 32'(out_inexact), 32'(vecs[i].inexact));
    endtask

    initial begin
        vecs[0]  = mk(0, 0,    '0,                  0, 0, 0, 16'h4000, 0);
        vecs[1]  = mk(1, 0,    '0,                  0, 0, 0, 16'hC000, 0);
        vecs[2]  = mk(0, 1,    fb(253),             0, 0, 0, 16'h4600, 0);
        vecs[3]  = mk(0, 0,    fb(243),             0, 0, 0, 16'h4000, 1);
        vecs[4]  = mk(0, 0,    fb(244) | fb(243),   0, 0, 0, 16'h4002, 1);
        vecs[5]  = mk(0, 0,    fb(241),             0, 0, 0, 16'h4000, 1);
        vecs[6]  = mk(0, 0,    fb(243) | fb(241),   0, 0, 0, 16'h4001, 1);
        vecs[7]  = mk(0, 0,    '0,                  1, 1, 0, 16'h8000, 0);
        vecs[8]  = mk(0, 0,    '0,                  0, 1, 0, 16'h0000, 0);
        vecs[9]  = mk(0, 200,  '0,                  0, 0, 0, 16'h7FFF, 1);
        vecs[10] = mk(1, -200, '0,                  0, 0, 0, 16'hFFFF, 1);
        vecs[11] = mk(0, -1,   '0,                  0, 0, 0, 16'h3C00, 0);
        vecs[12] = mk(0, 112,  '0,                  0, 0, 0, 16'h7FFF, 0);
        vecs[13] = mk(0, 113,  '0,                  0, 0, 0, 16'h7FFF, 1);
        vecs[14] = mk(0, -112, '0,                  0, 0, 0, 16'h0001, 0);
        vecs[15] = mk(0, -113, '0,                  0, 0, 0, 16'h0001, 1);
        vecs[16] = mk(1, 0,    fb(243) | fb(241),   0, 0, 0, 16'hBFFF, 1);
        vecs[17] = mk(0, 2,    fb(253) | fb(252),   0, 0, 0, 16'h4B00, 0);
`ifdef POSIT_ACCUM_ROUND_TRUNC_EN
        vecs[18] = mk(0, 0,    fb(243),             0, 0, 1, 16'h4001, 1);
`else
        vecs[18] = mk(0, 0,    fb(243),             0, 0, 1, 16'h4000, 1);
`endif
        vecs[19] = mk(1, 200,  '0,                  1, 0, 0, 16'h8000, 0);

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_posit", 32'(out_posit), 32'd0);
        chk("rst_inexact", 32'(out_inexact), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) run_vec(i);

        // Back-to-back stream of five items, pipe empty on entry.
        repeat (3) @(negedge clk);
        for (int c = 0; c < 9; c++) begin
            if (c >= 3 && c < 8) begin
                chk($sformatf("stream%0d_valid", c - 3), 32'(out_valid), 32'd1);
                chk($sformatf("stream%0d_posit", c - 3), 32'(out_posit), 32'(vecs[c-3].posit));
                chk($sformatf("stream%0d_inexact", c - 3), 32'(out_inexact), 32'(vecs[c-3].inexact));
            end else begin
                chk($sformatf("stream_idle%0d", c), 32'(out_valid), 32'd0);
            end
            if (c < 5) drive(vecs[c], 1'b1);
            else       in_valid = 1'b0;
            @(negedge clk);
        end

        // Reset in cycle 2 of a stream kills everything in flight.
        repeat (3) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            drive(vecs[9 + c], 1'b1);
            if (c == 2) rst = 1'b1;
            @(negedge clk);
        end
        chk("midrst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("postrst_quiet%0d", c), 32'(out_valid), 32'd0);
        end
        run_vec(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
